// File: rtl/serial_rx_nibble.sv
// serial_rx_nibble: start/4-data/[parity]/stop receiver feeding a one-entry holding register with a VALID/READY handshake.
// Define PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module serial_rx_nibble (
    input  logic       clk,
    input  logic       RST,
    input  logic       ENB,
    input  logic       DIR,
    input  logic       S_IN,
    input  logic       READY,
    output logic [3:0] Q,
    output logic       VALID,
    output logic       BUSY,
    output logic       FRAME_ERR,
    output logic       PAR_ERR,
    output logic       OVERRUN
);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, DATA, STOP} state_t;
`endif

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic [3:0]  shift_q;
    logic [3:0]  shift_d;
    logic        dir_q;
    logic [3:0]  q_q;
    logic        valid_q;
    logic        busy_q;
    logic        frameErr_q;
    logic        overrun_q;
    logic        stopGood;
    logic        goodStopEdge;
    logic        loadOk;
`ifdef PARITY_EN
    logic        parBad_q;
    logic        parErr_q;
`endif

    always_comb begin
        shift_d = dir_q ? {shift_q[2:0], S_IN} : {S_IN, shift_q[3:1]};
`ifdef PARITY_EN
        stopGood = S_IN && !parBad_q;
`else
        stopGood = S_IN;
`endif
        goodStopEdge = ENB && (state_q == STOP) && stopGood;
        // A full holding register can still take a new nibble if it is being drained on this edge.
        loadOk = !valid_q || READY;
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q    <= IDLE;
            cnt_q      <= 2'd0;
            shift_q    <= 4'd0;
            dir_q      <= 1'b0;
            q_q        <= 4'd0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            frameErr_q <= 1'b0;
            overrun_q  <= 1'b0;
`ifdef PARITY_EN
            parBad_q   <= 1'b0;
            parErr_q   <= 1'b0;
`endif
        end else begin
            frameErr_q <= 1'b0;
`ifdef PARITY_EN
            parErr_q   <= 1'b0;
`endif
            if (goodStopEdge && loadOk) begin
                q_q     <= shift_q;
                valid_q <= 1'b1;
            end else begin
                if (goodStopEdge) begin
                    overrun_q <= 1'b1;
                end
                if (valid_q && READY) begin
                    valid_q <= 1'b0;
                end
            end

            if (ENB) begin
                case (state_q)
                    IDLE: begin
                        if (!S_IN) begin
                            state_q <= DATA;
                            cnt_q   <= 2'd0;
                            dir_q   <= DIR;
                            busy_q  <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_q <= shift_d;
                        cnt_q   <= cnt_q + 2'd1;
                        if (cnt_q == 2'd3) begin
`ifdef PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
`ifdef PARITY_EN
                    PARITY: begin
                        // Even parity: data bits plus parity bit must XOR to zero.
                        parBad_q <= ^{shift_q, S_IN};
                        state_q  <= STOP;
                    end
`endif
                    STOP: begin
                        frameErr_q <= !S_IN;
`ifdef PARITY_EN
                        parErr_q   <= parBad_q;
`endif
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign Q         = q_q;
    assign VALID     = valid_q;
    assign BUSY      = busy_q;
    assign FRAME_ERR = frameErr_q;
    assign OVERRUN   = overrun_q;
`ifdef PARITY_EN
    assign PAR_ERR   = parErr_q;
`else
    assign PAR_ERR   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_rx_nibble.sv
// Scoreboard bench for serial_rx_nibble: frames are built as bit lists, a frame-level model predicts loads/drops,
// and a negedge monitor pops expected nibbles whenever VALID and READY meet.
module tb_serial_rx_nibble;

    logic       clk = 1'b0;
    logic       RST = 1'b1;
    logic       ENB = 1'b0;
    logic       DIR = 1'b0;
    logic       S_IN = 1'b1;
    logic       READY = 1'b0;
    logic [3:0] Q;
    logic       VALID;
    logic       BUSY;
    logic       FRAME_ERR;
    logic       PAR_ERR;
    logic       OVERRUN;

    int         checks = 0;
    int         failures = 0;
    logic [3:0] expQ[$];
    bit         mValid = 1'b0;
    bit         mOverrun = 1'b0;
    logic [3:0] mQ = 4'd0;
    int         readyPct = 0;

    always #5 clk = ~clk;

    serial_rx_nibble dut (
        .clk       (clk),
        .RST       (RST),
        .ENB       (ENB),
        .DIR       (DIR),
        .S_IN      (S_IN),
        .READY     (READY),
        .Q         (Q),
        .VALID     (VALID),
        .BUSY      (BUSY),
        .FRAME_ERR (FRAME_ERR),
        .PAR_ERR   (PAR_ERR),
        .OVERRUN   (OVERRUN)
    );

    task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every accepted nibble must be the oldest one the model predicted would be loaded.
    always @(negedge clk) begin
        if (RST === 1'b0 && VALID === 1'b1 && READY === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL handshake: got Q=%b with nothing expected", Q);
            end else begin
                checkOutput("handshake Q", Q, expQ.pop_front());
            end
        end
    end

    function automatic logic randReady();
        return ($urandom_range(99, 0) < 32'(readyPct));
    endfunction

    task automatic applyStimulus(input logic rst, input logic enb, input logic dir, input logic sin,
                                 input logic rdy, input bit isStop, input bit parBad, input logic [3:0] nib);
        bit goodStop;
        RST = rst; ENB = enb; DIR = dir; S_IN = sin; READY = rdy;
        if (rst) begin
            mValid = 1'b0; mOverrun = 1'b0; mQ = 4'd0;
            expQ.delete();
        end else begin
            goodStop = isStop && enb && sin && !parBad;
            if (goodStop && (!mValid || rdy)) begin
                mValid = 1'b1;
                mQ = nib;
                expQ.push_back(nib);
            end else begin
                if (goodStop) mOverrun = 1'b1;
                if (mValid && rdy) mValid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("VALID", {3'b000, VALID}, {3'b000, mValid});
        checkOutput("OVERRUN", {3'b000, OVERRUN}, {3'b000, mOverrun});
        checkOutput("Q", Q, mQ);
        checkOutput("FRAME_ERR", {3'b000, FRAME_ERR}, {3'b000, (!rst && isStop && enb && !sin)});
        checkOutput("PAR_ERR", {3'b000, PAR_ERR}, {3'b000, (!rst && isStop && enb && parBad)});
    endtask

    task automatic idleTick(input logic rdy);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, rdy, 1'b0, 1'b0, 4'd0);
    endtask

    // holdAt inserts exactly three ENB=0 edges before that bit index; otherwise gaps are random up to maxGap.
    task automatic sendFrame(input logic [3:0] nib, input logic dir, input logic stopBit, input bit badPar,
                             input int maxGap, input int holdAt);
        logic frame[$];
        bit   pBad;
        int   gaps;
        pBad = 1'b0;
        frame.push_back(1'b0);
        for (int i = 0; i < 4; i++) frame.push_back(dir ? nib[3-i] : nib[i]);
`ifdef PARITY_EN
        frame.push_back(badPar ? ~(^nib) : (^nib));
        pBad = badPar;
`endif
        frame.push_back(stopBit);
        for (int i = 0; i < frame.size(); i++) begin
            gaps = (i == holdAt) ? 3 : int'($urandom_range(32'(maxGap), 0));
            for (int g = 0; g < gaps; g++)
                applyStimulus(1'b0, 1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                              randReady(), 1'b0, 1'b0, nib);
            applyStimulus(1'b0, 1'b1, (i == 0) ? dir : 1'($urandom_range(1, 0)), frame[i], randReady(),
                          (i == frame.size() - 1), pBad && (i == frame.size() - 1), nib);
        end
    endtask

    initial begin
        // Sequence 1: reset
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("reset Q", Q, 4'b0000);
        checkOutput("reset BUSY", {3'b000, BUSY}, 4'd0);
        checkOutput("reset VALID", {3'b000, VALID}, 4'd0);

        // Sequence 2: MSB first
        readyPct = 0;
        sendFrame(4'b1101, 1'b1, 1'b1, 1'b0, 0, -1);
        checkOutput("msb Q", Q, 4'b1101);
        checkOutput("msb VALID", {3'b000, VALID}, 4'd1);
        checkOutput("msb BUSY", {3'b000, BUSY}, 4'd0);
        idleTick(1'b1);

        // Sequence 3: LSB first, same line bits
        sendFrame(4'b1011, 1'b0, 1'b1, 1'b0, 0, -1);
        checkOutput("lsb Q", Q, 4'b1011);
        idleTick(1'b1);
        checkOutput("lsb accept VALID", {3'b000, VALID}, 4'd0);

        // Sequence 4: overrun
        sendFrame(4'b1101, 1'b1, 1'b1, 1'b0, 0, -1);
        sendFrame(4'b0011, 1'b1, 1'b1, 1'b0, 0, -1);
        checkOutput("overrun Q kept", Q, 4'b1101);
        checkOutput("overrun flag", {3'b000, OVERRUN}, 4'd1);
        idleTick(1'b1);
        idleTick(1'b0);
        checkOutput("overrun sticky", {3'b000, OVERRUN}, 4'd1);

        // Sequence 5: bad stop bit while a nibble is held
        sendFrame(4'b0110, 1'b1, 1'b1, 1'b0, 0, -1);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        checkOutput("start BUSY", {3'b000, BUSY}, 4'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        checkOutput("badstop FRAME_ERR", {3'b000, FRAME_ERR}, 4'd1);
        checkOutput("badstop BUSY", {3'b000, BUSY}, 4'd0);
        checkOutput("badstop Q kept", Q, 4'b0110);
        idleTick(1'b0);
        checkOutput("badstop pulse ends", {3'b000, FRAME_ERR}, 4'd0);
        checkOutput("badstop stays idle", {3'b000, BUSY}, 4'd0);
        idleTick(1'b1);

        // ENB held low mid-frame, with DIR wiggling after the start bit
        sendFrame(4'b1001, 1'b1, 1'b1, 1'b0, 0, 2);
        checkOutput("enb hold Q", Q, 4'b1001);
        idleTick(1'b1);

`ifdef PARITY_EN
        // Sequence 6: parity
        sendFrame(4'b1101, 1'b1, 1'b1, 1'b1, 0, -1);
        checkOutput("parity bad PAR_ERR", {3'b000, PAR_ERR}, 4'd1);
        checkOutput("parity bad no load", {3'b000, VALID}, 4'd0);
        sendFrame(4'b1101, 1'b1, 1'b1, 1'b0, 0, 3);
        checkOutput("parity good Q", Q, 4'b1101);
        checkOutput("parity good VALID", {3'b000, VALID}, 4'd1);
        idleTick(1'b1);
`endif

        // Partial frame cut by reset must leave no trace
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        checkOutput("midframe reset BUSY", {3'b000, BUSY}, 4'd0);
        checkOutput("midframe reset OVERRUN", {3'b000, OVERRUN}, 4'd0);
        sendFrame(4'b0101, 1'b0, 1'b1, 1'b0, 0, -1);
        checkOutput("after reset Q", Q, 4'b0101);

        // Randomized traffic with random READY, gaps, bad stops and bad parity
        readyPct = 50;
        for (int f = 0; f < 40; f++) begin
            sendFrame(4'($urandom), 1'($urandom_range(1, 0)), ($urandom_range(7, 0) != 0),
                      ($urandom_range(7, 0) == 0), 2, -1);
            for (int g = 0; g < int'($urandom_range(2, 0)); g++)
                applyStimulus(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b1,
                              randReady(), 1'b0, 1'b0, 4'd0);
        end
        readyPct = 100;
        for (int g = 0; g < 3; g++) idleTick(1'b1);

        checks++;
        if (expQ.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard drain: got %0d pending, expected 0", expQ.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
